// File: rtl/mdu_ctrl_pkg.sv
// Shared decode definitions for the RV32M multiply/divide sequencer.
// Holds the M-extension encodings and the sequencer state type.
package mdu_ctrl_pkg;

    localparam logic [6:0] INST_TYPE_R   = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } r_funct3m_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if it fits. Purely combinational.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic          fits;

    // The shifted remainder can exceed XLEN bits, so compare one bit wider.
    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign fits    = (shifted >= {1'b0, divisor});
    assign rem_out = fits ? XLEN'(shifted - {1'b0, divisor}) : shifted[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], fits};

endmodule

// File: rtl/mdu_ctrl.sv
// RV32M multiply/divide sequencer: single-cycle multiply, radix-2 restoring
// divide, valid/ready result port with flush and busy for the pipeline.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            busy
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e state_reg, state_next;
    r_funct3m_e funct3_reg, funct3_in;
    logic [CW-1:0]   cnt_reg;
    logic [XLEN-1:0] rem_reg, quo_reg, dvs_reg;
    logic            q_neg_reg, r_neg_reg;
    logic [XLEN-1:0] result_reg;
    logic [4:0]      rd_reg;

    logic                   accept;
    logic                   is_div_op, is_signed_div, is_rem_in;
    logic                   dvd_neg, dvs_neg, div_zero, div_ovf, div_special;
    logic [XLEN-1:0]        dvd_mag, dvs_mag, special_res;
    logic signed [XLEN:0]   mul_a, mul_b;
    logic signed [2*XLEN+1:0] mul_full;
    logic [XLEN-1:0]        mul_res;
    logic [XLEN-1:0]        rem_step, quo_step;
    logic [XLEN-1:0]        q_fix, r_fix, fix_res;

    assign funct3_in = r_funct3m_e'(in_funct3);
    assign accept    = in_valid && (state_reg == IDLE) && !flush;

    assign in_ready   = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign out_valid  = (state_reg == DONE);
    assign out_result = result_reg;
    assign out_rd     = rd_reg;

    // Multiply: one extra sign bit per operand covers signed, unsigned and mixed.
    assign mul_a    = {((funct3_in == F3_MULH) || (funct3_in == F3_MULHSU)) && in_rs1[XLEN-1], in_rs1};
    assign mul_b    = {(funct3_in == F3_MULH) && in_rs2[XLEN-1], in_rs2};
    assign mul_full = mul_a * mul_b;
    assign mul_res  = (funct3_in == F3_MUL) ? XLEN'(mul_full) : XLEN'(mul_full >>> XLEN);

    assign is_div_op     = in_funct3[2];
    assign is_signed_div = is_div_op && !in_funct3[0];
    assign is_rem_in     = in_funct3[1];

    assign dvd_neg = is_signed_div && in_rs1[XLEN-1];
    assign dvs_neg = is_signed_div && in_rs2[XLEN-1];
    assign dvd_mag = dvd_neg ? -in_rs1 : in_rs1;
    assign dvs_mag = dvs_neg ? -in_rs2 : in_rs2;

    assign div_zero    = (in_rs2 == '0);
    assign div_ovf     = is_signed_div && (in_rs1 == MOST_NEG) && (in_rs2 == '1);
    assign div_special = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem_in ? in_rs1 : '1;
        end else begin
            special_res = is_rem_in ? '0 : in_rs1;
        end
    end

    div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .divisor (dvs_reg),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // Quotient sign follows the operand signs, remainder follows the dividend.
    assign q_fix   = q_neg_reg ? -quo_reg : quo_reg;
    assign r_fix   = r_neg_reg ? -rem_reg : rem_reg;
    assign fix_res = ((funct3_reg == F3_REM) || (funct3_reg == F3_REMU)) ? r_fix : q_fix;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (is_div_op && !div_special) ? DIV : DONE;
                end
            end
            DIV: begin
                if (cnt_reg == '0) begin
                    state_next = FIX;
                end
            end
            FIX: state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            funct3_reg <= F3_MUL;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            result_reg <= '0;
            rd_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                funct3_reg <= funct3_in;
                rd_reg     <= in_rd;
                if (!is_div_op) begin
                    result_reg <= mul_res;
                end else if (div_special) begin
                    result_reg <= special_res;
                end else begin
                    rem_reg   <= '0;
                    quo_reg   <= dvd_mag;
                    dvs_reg   <= dvs_mag;
                    q_neg_reg <= dvd_neg ^ dvs_neg;
                    r_neg_reg <= dvd_neg;
                    cnt_reg   <= CNT_LOAD;
                end
            end else if (state_reg == DIV) begin
                rem_reg <= rem_step;
                quo_reg <= quo_step;
                if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - CW'(1);
                end
            end else if (state_reg == FIX) begin
                result_reg <= fix_res;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl against a plain-arithmetic
// reference model with a cycle-level availability model.
module tb_mdu_ctrl;

    localparam int XLEN = 32;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        flush     = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [31:0] in_rs1    = 32'd0;
    logic [31:0] in_rs2    = 32'd0;
    logic [4:0]  in_rd     = 5'd0;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    int total = 0;
    int bad   = 0;

    mdu_ctrl #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // Architectural result computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0] pu;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        pu = {32'd0, a} * {32'd0, b};
        p  = 64'sd0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from accept to the first cycle out_valid is seen high.
    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 1;
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Availability model: busy from accept until consumed or flushed.
    logic        m_busy, m_valid;
    int          m_left;
    logic [31:0] m_res;
    logic [4:0]  m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_left  <= 0;
            m_res   <= 32'd0;
            m_rd    <= 5'd0;
        end else if (flush) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy  <= 1'b1;
                m_res   <= ref_op(in_funct3, in_rs1, in_rs2);
                m_rd    <= in_rd;
                m_valid <= (ref_lat(in_funct3, in_rs1, in_rs2) == 1);
                m_left  <= ref_lat(in_funct3, in_rs1, in_rs2) - 1;
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
            end
        end else begin
            if (m_left == 1) m_valid <= 1'b1;
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'(!m_busy));
            check("busy", 32'(busy), 32'(m_busy));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("out_result", out_result, m_res);
                check("out_rd", 32'(out_rd), 32'(m_rd));
            end
        end
    end

    // Issue one op from a negedge, wait for its result, hold off, consume.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold,
                         output logic [31:0] got, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        check("ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = rd;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_rs1 = $urandom; in_rs2 = $urandom; in_rd = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
        check("valid_wait", 32'(out_valid), 32'd1);
        got = out_result;
        check("rd_echo", 32'(out_rd), 32'(rd));
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check("hold_result", out_result, got);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        $display("op f3=%0d a=%h b=%h rd=%0d -> %h lat=%0d", f3, a, b, rd, got, lat);
    endtask

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        logic [7:0]  lat;
    } vec_t;

    localparam vec_t VECS [12] = '{
        '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd1},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd1},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd1},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8'd1},
        '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 8'd34},
        '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 8'd34},
        '{3'd5, 32'd100,       32'd7,         32'd14,        8'd34},
        '{3'd7, 32'd100,       32'd7,         32'd2,         8'd34},
        '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 8'd1},
        '{3'd6, 32'd5,         32'd0,         32'd5,         8'd1},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd1},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         8'd1}
    };

    initial begin
        logic [31:0] got, a, b;
        logic [2:0]  f3;
        logic [4:0]  rd;
        int          lat, n, k;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            check("model_pin", ref_op(VECS[i].f3, VECS[i].a, VECS[i].b), VECS[i].e);
            do_op(VECS[i].f3, VECS[i].a, VECS[i].b, 5'(i + 1), 0, got, lat);
            check("dir_result", got, VECS[i].e);
            check("dir_latency", 32'(lat), 32'(VECS[i].lat));
        end

        // Flush a divide mid-flight, then a multiply must come back clean.
        in_valid = 1'b1; in_funct3 = 3'd4; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_rd = 5'd17;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        do_op(3'd0, 32'd7, 32'd6, 5'd3, 0, got, lat);
        check("post_flush_mul", got, 32'd42);
        check("post_flush_lat", 32'(lat), 32'd1);

        // Backpressure for 20 cycles.
        do_op(3'd5, 32'd100, 32'd7, 5'd9, 20, got, lat);
        check("bp_result", got, 32'd14);
        check("bp_latency", 32'(lat), 32'd34);

        // Asynchronous reset in the middle of a divide.
        in_valid = 1'b1; in_funct3 = 3'd5; in_rs1 = 32'd999; in_rs2 = 32'd4; in_rd = 5'd21;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_result", out_result, 32'd0);
        check("arst_out_rd", 32'(out_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 250; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            rd = 5'($urandom);
            do_op(f3, a, b, rd, $urandom_range(0, 3), got, lat);
            check("rnd_result", got, ref_op(f3, a, b));
            check("rnd_latency", 32'(lat), 32'(ref_lat(f3, a, b)));
        end

        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (!in_ready && n < 200) begin @(negedge clk); n++; end
            check("fl_ready_wait", 32'(in_ready), 32'd1);
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = 5'($urandom);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            k = $urandom_range(0, 40);
            repeat (k) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            out_ready = 1'($urandom_range(0, 1));
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            out_ready = 1'b0;
            check("fl_idle", 32'(busy), 32'd0);
            $display("flush f3=%0d a=%h b=%h after %0d cycles", f3, a, b, k);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
